ps2_game_key_decoder: RTL and testbench
=======================================

Name: ps2_game_key_decoder

Overview:
Converts the raw PS/2 scan-code byte stream from the keyboard interface into registered game-control signals for the processor and the VGA game controller. Outputs are move_left, move_right, fire and pause. It parses set-2 make, break (F0) and extended (E0) sequences and tracks which keys are held. It also suppresses typematic auto-repeat, so that fire is a single-cycle pulse per physical press and pause toggles once per press.

Parameters:
LEFT_CODE, 8'h6B, scan code of the left arrow; matched only when E0-prefixed.
RIGHT_CODE, 8'h74, scan code of the right arrow; matched only when E0-prefixed.
FIRE_CODE, 8'h29, scan code of space; matched only when not prefixed.
PAUSE_CODE, 8'h4D, scan code of P; matched only when not prefixed.
PREFIX_TIMEOUT, 500000, clock cycles without a byte before a pending prefix is discarded (10 ms at 50 MHz).

Ports:
clock  input  1  system clock
resetn  input  1  asynchronous active-low reset
ps2_key_data  input  8  received scan-code byte, valid when ps2_key_pressed=1
ps2_key_pressed  input  1  one-cycle strobe per received byte
move_left  output  1  level: left is the active horizontal direction
move_right  output  1  level: right is the active horizontal direction
fire  output  1  one-cycle pulse per fire key press
pause  output  1  level: game paused; toggles per pause key press
last_code  output  8  last non-prefix code byte accepted, for LCD/seven-segment debug

Behaviour:
- Reset (resetn=0, asynchronous):
  - All outputs are 0 and last_code is 8'h00.
  - Parser goes to IDLE; all held flags and the timeout counter are cleared.
- Parser FSM advances only on cycles with ps2_key_pressed=1, except for the timeout.
  - IDLE: E0 -> EXT. F0 -> BRK. FA, AA, EE, FE, E1 are ignored and the state stays IDLE. Any other byte is a plain make; state stays IDLE.
  - EXT: F0 -> EXT_BRK. E0 -> EXT (repeated prefix is tolerated). Any other byte is an extended make -> IDLE.
  - BRK: any byte is a plain break -> IDLE.
  - EXT_BRK: any byte is an extended break -> IDLE.
  - Timeout: in EXT, BRK or EXT_BRK, the counter increments each cycle without a strobe. When it reaches PREFIX_TIMEOUT-1, the FSM returns to IDLE with no key event. The counter clears on every strobe and on entering IDLE.
- Key event processing on a make or break code:
  - The event is applied in the same clock edge that consumes the final byte.
  - Outputs are visible the cycle after the strobe (1-cycle latency).
  - last_code is loaded with the final byte of every make or break. Prefix bytes and ignored bytes do not load it.
- Held flags: left_held, right_held, fire_held, pause_held.
  - A make sets the matching flag; a break clears it.
  - Codes that do not match a parameter have no effect other than loading last_code.
- Horizontal priority (a 1-bit last_dir register):
  - A left make sets last_dir to left; a right make sets it to right.
  - move_left = left_held & (~right_held | last_dir==left).
  - move_right = right_held & (~left_held | last_dir==right).
  - move_left and move_right are never both 1.
  - On release of the winning key, the other key (if still held) becomes active on the next cycle.
- Fire:
  - fire=1 for exactly one cycle on a fire make when fire_held was 0.
  - Typematic repeats (make while fire_held=1) produce no pulse.
  - fire is 0 in every other cycle.
- Pause:
  - pause toggles on a pause make when pause_held was 0.
  - Repeats while pause_held=1 do not toggle it.
- fire and pause are independent of each other and of movement. Events on different strobes never interact.
- A strobe arriving in the same cycle the timeout fires: the strobe wins. The byte is interpreted in the current prefix state and the timeout is ignored.
- resetn asserted mid-sequence abandons any partial sequence; no event is produced.
- A move key's prefix-less code (keypad 6B/74) is not a match. It loads last_code and has no other effect.

Test Plan:
- Strobe bytes E0, 6B -> move_left=1 the cycle after the 6B strobe, move_right=0, last_code=6B. Then E0, F0, 6B -> move_left=0 the cycle after the final strobe.
- Left make, then right make, then right break (E0 F0 74) -> move_left=1, then move_right=1 with move_left=0, then move_left=1 again.
- Bytes 29, 29, 29 (typematic), then F0 29, then 29 -> exactly two one-cycle fire pulses: one after the first 29 and one after the final 29.
- Bytes 4D, 4D, F0 4D, 4D, F0 4D -> pause goes 0→1 after the first 4D, stays 1 through the repeat and break, then goes 1→0 after the third 4D.
- Byte E0, then 500000 idle cycles, then 6B -> the prefix is dropped and 6B is a plain make: move_left stays 0, last_code=6B.
- Assert resetn=0 after E0 F0 with left held -> all outputs go to 0 immediately. After release, the byte 6B alone leaves move_left=0.

Source files
------------

// File: rtl/ps2_game_key_decoder.sv
// ps2_game_key_decoder: parses set-2 make/break/extended scan codes into registered game controls
module ps2_game_key_decoder #(
    parameter logic [7:0] LEFT_CODE      = 8'h6B,
    parameter logic [7:0] RIGHT_CODE     = 8'h74,
    parameter logic [7:0] FIRE_CODE      = 8'h29,
    parameter logic [7:0] PAUSE_CODE     = 8'h4D,
    parameter int         PREFIX_TIMEOUT = 500000
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic [7:0] ps2_key_data,
    input  logic       ps2_key_pressed,
    output logic       move_left,
    output logic       move_right,
    output logic       fire,
    output logic       pause,
    output logic [7:0] last_code
);
    localparam int CW = (PREFIX_TIMEOUT > 2) ? $clog2(PREFIX_TIMEOUT) : 1;

    typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            left_q, left_d, right_q, right_d, fire_held_q, fire_held_d;
    logic            pause_held_q, pause_held_d, dir_q, dir_d;
    logic            move_left_q, move_left_d, move_right_q, move_right_d;
    logic            fire_q, fire_d, pause_q, pause_d;
    logic [7:0]      last_q, last_d;
    logic            ev, ev_ext, ev_brk, ign;
    logic            hit_l, hit_r, hit_f, hit_p;

    assign ign = ps2_key_data inside {8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'hE1};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ev      = 1'b0;
        ev_ext  = 1'b0;
        ev_brk  = 1'b0;
        if (ps2_key_pressed) begin
            cnt_d = '0;
            case (state_q)
                IDLE: begin
                    state_d = (ps2_key_data == 8'hE0) ? EXT : (ps2_key_data == 8'hF0) ? BRK : IDLE;
                    ev      = !(ps2_key_data inside {8'hE0, 8'hF0}) && !ign;
                end
                EXT: begin
                    state_d = (ps2_key_data == 8'hF0) ? EXT_BRK : (ps2_key_data == 8'hE0) ? EXT : IDLE;
                    ev      = !(ps2_key_data inside {8'hE0, 8'hF0});
                    ev_ext  = 1'b1;
                end
                BRK: begin
                    state_d = IDLE;
                    ev      = 1'b1;
                    ev_brk  = 1'b1;
                end
                default: begin
                    state_d = IDLE;
                    ev      = 1'b1;
                    ev_ext  = 1'b1;
                    ev_brk  = 1'b1;
                end
            endcase
        end else if (state_q != IDLE) begin
            // a prefix left dangling too long is dropped without producing an event
            state_d = (cnt_q == CW'(PREFIX_TIMEOUT - 1)) ? IDLE : state_q;
            cnt_d   = (cnt_q == CW'(PREFIX_TIMEOUT - 1)) ? '0 : cnt_q + 1'b1;
        end
    end

    assign hit_l = ev && ev_ext && (ps2_key_data == LEFT_CODE);
    assign hit_r = ev && ev_ext && (ps2_key_data == RIGHT_CODE);
    assign hit_f = ev && !ev_ext && (ps2_key_data == FIRE_CODE);
    assign hit_p = ev && !ev_ext && (ps2_key_data == PAUSE_CODE);

    always_comb begin
        left_d       = hit_l ? !ev_brk : left_q;
        right_d      = hit_r ? !ev_brk : right_q;
        fire_held_d  = hit_f ? !ev_brk : fire_held_q;
        pause_held_d = hit_p ? !ev_brk : pause_held_q;
        dir_d        = (hit_l && !ev_brk) ? 1'b0 : (hit_r && !ev_brk) ? 1'b1 : dir_q;
        fire_d       = hit_f && !ev_brk && !fire_held_q;
        pause_d      = pause_q ^ (hit_p && !ev_brk && !pause_held_q);
        last_d       = ev ? ps2_key_data : last_q;
        move_left_d  = left_d && (!right_d || !dir_d);
        move_right_d = right_d && (!left_d || dir_d);
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            left_q       <= 1'b0;
            right_q      <= 1'b0;
            fire_held_q  <= 1'b0;
            pause_held_q <= 1'b0;
            dir_q        <= 1'b0;
            move_left_q  <= 1'b0;
            move_right_q <= 1'b0;
            fire_q       <= 1'b0;
            pause_q      <= 1'b0;
            last_q       <= 8'h00;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            left_q       <= left_d;
            right_q      <= right_d;
            fire_held_q  <= fire_held_d;
            pause_held_q <= pause_held_d;
            dir_q        <= dir_d;
            move_left_q  <= move_left_d;
            move_right_q <= move_right_d;
            fire_q       <= fire_d;
            pause_q      <= pause_d;
            last_q       <= last_d;
        end
    end

    assign move_left  = move_left_q;
    assign move_right = move_right_q;
    assign fire       = fire_q;
    assign pause      = pause_q;
    assign last_code  = last_q;
endmodule

// File: tb/tb_ps2_game_key_decoder.sv
// tb_ps2_game_key_decoder: directed and random scan-code streams checked against a behavioural key model
module tb_ps2_game_key_decoder;
    localparam int T = 40;

    logic       clock, resetn, ps2_key_pressed;
    logic [7:0] ps2_key_data;
    logic       move_left, move_right, fire, pause;
    logic [7:0] last_code;

    int checks, failures, idle_n;
    bit m_ext, m_brk, lh, rh, fh, ph, dir, m_fire, m_pause;
    logic [7:0] m_last;
    logic [7:0] alpha [10] = '{8'hE0, 8'hF0, 8'h6B, 8'h74, 8'h29, 8'h4D, 8'hFA, 8'h12, 8'hE1, 8'hE0};

    ps2_game_key_decoder #(.PREFIX_TIMEOUT(T)) dut (
        .clock(clock), .resetn(resetn), .ps2_key_data(ps2_key_data),
        .ps2_key_pressed(ps2_key_pressed), .move_left(move_left), .move_right(move_right),
        .fire(fire), .pause(pause), .last_code(last_code)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [11:0] got, input logic [11:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [11:0] obs();
        return {move_left, move_right, fire, pause, last_code};
    endfunction

    function automatic logic [11:0] expv();
        return {lh & (!rh | !dir), rh & (!lh | dir), m_fire, m_pause, m_last};
    endfunction

    task automatic model_reset();
        {m_ext, m_brk, lh, rh, fh, ph, dir, m_fire, m_pause} = '0;
        m_last = 8'h00;
        idle_n = 0;
    endtask

    task automatic model_byte(input logic [7:0] b);
        bit ev, ext, brk;
        ev = 0; ext = 0; brk = 0;
        m_fire = 0;
        if (idle_n >= T) begin m_ext = 0; m_brk = 0; end
        if (!m_brk && b == 8'hF0) m_brk = 1;
        else if (!m_brk && b == 8'hE0) m_ext = 1;
        else if (!m_ext && !m_brk && (b inside {8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'hE1})) ev = 0;
        else begin ev = 1; ext = m_ext; brk = m_brk; m_ext = 0; m_brk = 0; end
        if (ev) begin
            m_last = b;
            if (ext && b == 8'h6B) begin lh = !brk; if (!brk) dir = 0; end
            if (ext && b == 8'h74) begin rh = !brk; if (!brk) dir = 1; end
            if (!ext && b == 8'h29) begin if (!brk && !fh) m_fire = 1; fh = !brk; end
            if (!ext && b == 8'h4D) begin if (!brk && !ph) m_pause = !m_pause; ph = !brk; end
        end
    endtask

    task automatic send(input logic [7:0] b);
        ps2_key_data = b;
        ps2_key_pressed = 1'b1;
        @(posedge clock);
        #1 ps2_key_pressed = 1'b0;
        model_byte(b);
        idle_n = 0;
        chk("byte", obs(), expv());
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1 idle_n++;
            m_fire = 0;
            chk("idle", obs(), expv());
        end
    endtask

    initial begin
        checks = 0; failures = 0;
        ps2_key_pressed = 1'b0; ps2_key_data = 8'h00; resetn = 1'b0;
        model_reset();
        #12 chk("reset", obs(), 12'h000);
        @(posedge clock); #1 resetn = 1'b1;
        idle(2);

        send(8'hE0); send(8'h6B);
        chk("left_make", {move_left, move_right, last_code}, {2'b10, 8'h6B});
        send(8'hE0); send(8'hF0); send(8'h6B);
        chk("left_break", {11'd0, move_left}, 12'd0);

        send(8'hE0); send(8'h6B); send(8'hE0); send(8'h74);
        chk("right_wins", {10'd0, move_left, move_right}, 12'b01);
        send(8'hE0); send(8'hF0); send(8'h74);
        chk("left_back", {10'd0, move_left, move_right}, 12'b10);
        send(8'hE0); send(8'hF0); send(8'h6B);

        send(8'h29);
        chk("fire_pulse", {11'd0, fire}, 12'd1);
        idle(1); send(8'h29); send(8'h29);
        chk("fire_repeat", {11'd0, fire}, 12'd0);
        send(8'hF0); send(8'h29); send(8'h29);
        chk("fire_again", {11'd0, fire}, 12'd1);
        idle(2);

        send(8'h4D);
        chk("pause_on", {11'd0, pause}, 12'd1);
        send(8'h4D); send(8'hF0); send(8'h4D);
        chk("pause_hold", {11'd0, pause}, 12'd1);
        send(8'h4D);
        chk("pause_off", {11'd0, pause}, 12'd0);
        send(8'hF0); send(8'h4D);

        send(8'hE0); idle(T); send(8'h6B);
        chk("timeout_drop", {3'd0, move_left, last_code}, {4'd0, 8'h6B});
        send(8'hE0); idle(T - 3); send(8'h6B);
        chk("no_timeout", {11'd0, move_left}, 12'd1);
        send(8'hFA);
        chk("ignored", {4'd0, last_code}, {4'd0, 8'h6B});

        send(8'hE0); send(8'hF0);
        #3 resetn = 1'b0;
        #1 chk("async_reset", obs(), 12'h000);
        model_reset();
        #2 resetn = 1'b1;
        send(8'h6B);
        chk("after_reset", {3'd0, move_left, last_code}, {4'd0, 8'h6B});

        for (int k = 0; k < 400; k++) begin
            int r;
            send(alpha[$urandom_range(0, 9)]);
            r = $urandom_range(0, 24);
            idle(r == 0 ? T + 5 : r % 4);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
